// File: rtl/map_req_if.sv
// map_req_if: object request bus between a requester and the map server
interface map_req_if;
    logic        req;
    logic [1:0]  req_type;
    logic [7:0]  req_content;
    logic        ACK;
    logic        NACK;
    logic        wr;
    logic [15:0] data_out;
    modport master (output req, req_type, req_content, input ACK, NACK, wr, data_out);
    modport slave (input req, req_type, req_content, output ACK, NACK, wr, data_out);
endinterface

// File: rtl/map_req_server.sv
// map_req_server: owns the 16x16 tile map, serves one request at a time with ACK/NACK and feeds the VGA renderer
module map_req_server #(
    parameter int         RESP_DELAY = 2,
    parameter logic [1:0] RESET_TILE = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    map_req_if.slave   bus,
    input  logic [7:0] vga_addr,
    output logic [1:0] vga_tile
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, DROP = 2'd3;
    logic [1:0]  state_q, state_d, type_q, type_d, vga_tile_q, tile;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        ack_q, ack_d, nack_q, nack_d, wr_q, wr_d;
    logic        writes, grant, dig_we;
    logic [1:0]  map_q [256];
    always_comb begin
        tile    = map_q[addr_q];
        writes  = type_q == 2'b00 || (type_q == 2'b01 && tile != 2'b11);
        grant   = writes || (type_q == 2'b10 && tile == 2'b00);
        ack_d   = state_q == RESP && grant;
        nack_d  = state_q == RESP && !grant;
        wr_d    = state_q == RESP && writes;
        data_d  = wr_d ? {addr_q, 6'b0, tile} : data_q;
        dig_we  = state_q == RESP && type_q == 2'b01 && ^tile;
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d = BUSY;
                cnt_d   = 4'd0;
                type_d  = bus.req_type;
                addr_d  = bus.req_content;
            end
            BUSY: if (cnt_q == 4'(RESP_DELAY - 1)) state_d = RESP;
                  else cnt_d = cnt_q + 4'd1;
            RESP: state_d = DROP;
            default: if (!bus.req) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            type_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            wr_q       <= 1'b0;
            vga_tile_q <= '0;
            for (int i = 0; i < 256; i++) map_q[i] <= RESET_TILE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            wr_q       <= wr_d;
            vga_tile_q <= map_q[vga_addr];
            if (dig_we) map_q[addr_q] <= 2'b00;
        end
    end
    assign bus.ACK      = ack_q;
    assign bus.NACK     = nack_q;
    assign bus.wr       = wr_q;
    assign bus.data_out = data_q;
    assign vga_tile     = vga_tile_q;
endmodule
